plab4_net_msg_adapter: RTL

- Terminal-side network interface for one ring port. It sits directly upstream and downstream of the ring network port.
- Injection path: takes terminal requests (dest, payload), stamps src = router id and a rolling opaque tag, registers the resulting net message and drives the network input port.
- Ejection path: buffers messages leaving the network output port in a 2-entry FIFO, unpacks them for the terminal, and enforces a cap on outstanding injected messages.

---
 rtl/plab4_net_msg_adapter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/plab4_net_msg_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : plab4_net_msg_adapter
//  Description : Terminal-side interface for one ring port. The injection
//                path stamps src/opaque onto terminal requests and registers
//                them toward the network. The ejection path buffers network
//                output in a 2-entry queue and unpacks it for the terminal.
//                It also caps the number of outstanding injected messages.
//  Revision    : 1.0 - initial release
// ============================================================================
module plab4_net_msg_adapter #(
    parameter int p_payload_nbits = 32,
    parameter int p_opaque_nbits  = 3,
    parameter int p_srcdest_nbits = 3,
    parameter int p_router_id     = 0,
    parameter int p_max_inflight  = 4,
    localparam int c_msg_nbits    = 2*p_srcdest_nbits + p_opaque_nbits + p_payload_nbits,
    localparam int c_inf_nbits    = $clog2(p_max_inflight + 1)
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       req_val,
    output logic                       req_rdy,
    input  logic [p_srcdest_nbits-1:0] req_dest,
    input  logic [p_payload_nbits-1:0] req_payload,

    output logic                       net_in_val,
    input  logic                       net_in_rdy,
    output logic [c_msg_nbits-1:0]     net_in_msg,

    input  logic                       net_out_val,
    output logic                       net_out_rdy,
    input  logic [c_msg_nbits-1:0]     net_out_msg,

    output logic                       resp_val,
    input  logic                       resp_rdy,
    output logic [p_srcdest_nbits-1:0] resp_src,
    output logic [p_opaque_nbits-1:0]  resp_opaque,
    output logic [p_payload_nbits-1:0] resp_payload,

    output logic [c_inf_nbits-1:0]     inflight,
    output logic                       misroute_err
);

    // A queue entry keeps everything except dest, which is known to be ours.
    localparam int c_ent_nbits = c_msg_nbits - p_srcdest_nbits;

    localparam logic [p_srcdest_nbits-1:0] c_rid     = p_srcdest_nbits'(p_router_id);
    localparam logic [c_inf_nbits-1:0]     c_inf_max = c_inf_nbits'(p_max_inflight);
    localparam logic [c_inf_nbits-1:0]     c_inf_one = c_inf_nbits'(1);
    localparam logic [p_opaque_nbits-1:0]  c_opq_one = p_opaque_nbits'(1);

    logic                        r_inj_val;
    logic [c_msg_nbits-1:0]      r_inj_msg;
    logic [p_opaque_nbits-1:0]   r_opq_cnt;

    logic [c_ent_nbits-1:0]      r_ent0;
    logic [c_ent_nbits-1:0]      r_ent1;
    logic [1:0]                  r_cnt;

    logic [c_inf_nbits-1:0]      r_inflight;
    logic                        r_err;

    logic                        w_req_fire;
    logic                        w_out_fire;
    logic                        w_route_ok;
    logic                        w_enq;
    logic                        w_deq;
    logic                        w_underflow;
    logic [p_srcdest_nbits-1:0]  w_out_dest;
    logic [c_ent_nbits-1:0]      w_new_ent;

    // Handshake and routing decode. Valids come only from registers, so no
    // valid ever depends combinationally on a ready.
    assign req_rdy     = (!r_inj_val | net_in_rdy) & (r_inflight < c_inf_max);
    assign w_req_fire  = req_val & req_rdy;

    assign net_out_rdy = (r_cnt != 2'd2);
    assign w_out_fire  = net_out_val & net_out_rdy;
    assign w_out_dest  = net_out_msg[c_msg_nbits-1 -: p_srcdest_nbits];
    assign w_new_ent   = net_out_msg[c_ent_nbits-1:0];
    assign w_route_ok  = (w_out_dest == c_rid);
    assign w_enq       = w_out_fire & w_route_ok;

    assign resp_val    = (r_cnt != 2'd0);
    assign w_deq       = resp_val & resp_rdy;

    // A correct ejection with nothing outstanding cannot happen legally.
    assign w_underflow = w_enq & !w_req_fire & (r_inflight == '0);

    assign net_in_val   = r_inj_val;
    assign net_in_msg   = r_inj_msg;
    assign resp_src     = r_ent0[c_ent_nbits-1 -: p_srcdest_nbits];
    assign resp_opaque  = r_ent0[p_payload_nbits +: p_opaque_nbits];
    assign resp_payload = r_ent0[p_payload_nbits-1:0];
    assign inflight     = r_inflight;
    assign misroute_err = r_err;

    // Injection register: load on accept, clear when the network takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inj_val <= 1'b0;
            r_inj_msg <= '0;
            r_opq_cnt <= '0;
        end else if (w_req_fire) begin
            r_inj_val <= 1'b1;
            r_inj_msg <= {req_dest, c_rid, r_opq_cnt, req_payload};
            r_opq_cnt <= r_opq_cnt + c_opq_one;
        end else if (net_in_rdy) begin
            r_inj_val <= 1'b0;
        end
    end

    // Two-entry shift queue; r_ent0 is always the head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({w_enq, w_deq})
                2'b10: begin
                    if (r_cnt == 2'd0) r_ent0 <= w_new_ent;
                    else               r_ent1 <= w_new_ent;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_ent0 <= w_new_ent;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_new_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outstanding count: up on accept, down on correct ejection, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
        end else if (w_req_fire && !w_enq) begin
            r_inflight <= r_inflight + c_inf_one;
        end else if (w_enq && !w_req_fire && (r_inflight != '0)) begin
            r_inflight <= r_inflight - c_inf_one;
        end
    end

    // Sticky error on misrouted arrivals or count underflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if ((w_out_fire && !w_route_ok) || w_underflow) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
